hazard_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage MIPS core. It is the producer of the `flushe` and stall controls consumed by the ID/EX pipeline register and the earlier stage registers. It also generates EX- and ID-stage forwarding selects. It runs a small state machine that drains the pipeline and hands a `syscall` in EX to an external handler over a req/ack handshake.

---
 rtl/mips_pkg.sv | 34 +++
 rtl/fwd_unit.sv | 31 +++
 rtl/hazard_ctrl.sv | 132 +++++++++++++
 tb/tb_hazard_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the MIPS pipeline hazard logic.
//   state_e     - syscall drain/handshake FSM states.
//   FWD_*       - EX-stage forward-select encodings.
//   ex_fwd_sel  - EX forward select for one source operand (MEM beats WB).
package mips_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        REQ   = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    // Register $0 is hardwired to zero, so it never takes a forwarded value.
    function automatic logic [1:0] ex_fwd_sel(
        input logic [4:0] src,
        input logic [4:0] wregm,
        input logic       rwm,
        input logic [4:0] wregw,
        input logic       rww
    );
        if (src != 5'd0 && rwm && wregm == src)
            return FWD_MEM;
        else if (src != 5'd0 && rww && wregw == src)
            return FWD_WB;
        else
            return FWD_NONE;
    endfunction

endpackage

// File: rtl/fwd_unit.sv
// fwd_unit: combinational forwarding selects.
//   rse, rte           - EX source registers.
//   rsd, rtd           - ID source registers (branch comparator).
//   writeregm/w        - destination registers in MEM / WB.
//   regwritem/w        - write enables in MEM / WB.
//   forwardae/be       - EX operand selects (FWD_MEM / FWD_WB / FWD_NONE).
//   forwardad/bd       - ID comparator operand taken from the MEM ALU result.
module fwd_unit
    import mips_pkg::*;
(
    input  logic [4:0] rse,
    input  logic [4:0] rte,
    input  logic [4:0] rsd,
    input  logic [4:0] rtd,
    input  logic [4:0] writeregm,
    input  logic [4:0] writeregw,
    input  logic       regwritem,
    input  logic       regwritew,
    output logic [1:0] forwardae,
    output logic [1:0] forwardbe,
    output logic       forwardad,
    output logic       forwardbd
);

    assign forwardae = ex_fwd_sel(rse, writeregm, regwritem, writeregw, regwritew);
    assign forwardbe = ex_fwd_sel(rte, writeregm, regwritem, writeregw, regwritew);

    assign forwardad = (rsd != 5'd0) && regwritem && (writeregm == rsd);
    assign forwardbd = (rtd != 5'd0) && regwritem && (writeregm == rtd);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the five-stage MIPS core.
//   Inputs : ID/EX source registers, EX/MEM/WB destinations and write
//            enables, load flags, branchd, syscalle, syscall_ack.
//   Outputs: stallf/stalld (hold PC and IF/ID), flushe (bubble ID/EX),
//            forwarding selects, syscall_req (registered), busy.
// A syscall in EX is flushed, the pipeline is drained for DRAIN_CYCLES,
// then an external handler is engaged over a level req/ack handshake.
module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 2   // legal range 1..7
)(
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rsd,
    input  logic [4:0] rtd,
    input  logic [4:0] rse,
    input  logic [4:0] rte,
    input  logic [4:0] writerege,
    input  logic [4:0] writeregm,
    input  logic [4:0] writeregw,
    input  logic       regwritee,
    input  logic       regwritem,
    input  logic       regwritew,
    input  logic       memtorege,
    input  logic       memtoregm,
    input  logic       branchd,
    input  logic       syscalle,
    input  logic       syscall_ack,
    output logic       stallf,
    output logic       stalld,
    output logic       flushe,
    output logic       forwardad,
    output logic       forwardbd,
    output logic [1:0] forwardae,
    output logic [1:0] forwardbe,
    output logic       syscall_req,
    output logic       busy
);

    state_e     state, state_nxt;
    logic [2:0] drain_cnt, drain_cnt_nxt;
    logic       req_nxt;
    logic       fsm_stall;
    logic       lwstall, brstall, stall;

    fwd_unit u_fwd (
        .rse       (rse),
        .rte       (rte),
        .rsd       (rsd),
        .rtd       (rtd),
        .writeregm (writeregm),
        .writeregw (writeregw),
        .regwritem (regwritem),
        .regwritew (regwritew),
        .forwardae (forwardae),
        .forwardbe (forwardbe),
        .forwardad (forwardad),
        .forwardbd (forwardbd)
    );

    // Load in EX feeding the instruction in ID.
    assign lwstall = memtorege && ((rte == rsd) || (rte == rtd));

    // Branch operands are compared in ID: wait for an ALU result still in
    // EX, or a load result still in MEM.
    assign brstall = branchd &&
                     ((regwritee && ((writerege == rsd) || (writerege == rtd))) ||
                      (memtoregm && ((writeregm == rsd) || (writeregm == rtd))));

    assign stall  = lwstall || brstall || fsm_stall;
    assign stallf = stall;
    assign stalld = stall;
    assign flushe = stall;
    assign busy   = (state != RUN);

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        req_nxt       = syscall_req;
        fsm_stall     = 1'b1;
        unique case (state)
            RUN: begin
                // Gated by reset so a syscall held during reset cannot stall.
                fsm_stall = syscalle && !reset;
                if (syscalle) begin
                    state_nxt     = DRAIN;
                    drain_cnt_nxt = 3'(DRAIN_CYCLES);
                end
            end
            DRAIN: begin
                drain_cnt_nxt = drain_cnt - 3'd1;
                if (drain_cnt == 3'd1) begin
                    state_nxt = REQ;
                    req_nxt   = 1'b1;
                end
            end
            REQ: begin
                if (syscall_ack) begin
                    state_nxt = DONE;
                    req_nxt   = 1'b0;
                end
            end
            DONE: begin
                // Handler holds ack until it sees req low; wait for it to drop.
                if (!syscall_ack)
                    state_nxt = RUN;
            end
            default: begin
                state_nxt = RUN;
                req_nxt   = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            drain_cnt   <= 3'd0;
            syscall_req <= 1'b0;
        end else begin
            state       <= state_nxt;
            drain_cnt   <= drain_cnt_nxt;
            syscall_req <= req_nxt;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed, table-driven bench for hazard_ctrl
// (DRAIN_CYCLES = 2), plus hand-written syscall handshake sequences.
module tb_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] rsd, rtd, rse, rte;
    logic [4:0] writerege, writeregm, writeregw;
    logic       regwritee, regwritem, regwritew;
    logic       memtorege, memtoregm, branchd;
    logic       syscalle, syscall_ack;
    logic       stallf, stalld, flushe;
    logic       forwardad, forwardbd;
    logic [1:0] forwardae, forwardbe;
    logic       syscall_req, busy;

    int checks   = 0;
    int failures = 0;

    hazard_ctrl #(.DRAIN_CYCLES(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .rsd         (rsd),
        .rtd         (rtd),
        .rse         (rse),
        .rte         (rte),
        .writerege   (writerege),
        .writeregm   (writeregm),
        .writeregw   (writeregw),
        .regwritee   (regwritee),
        .regwritem   (regwritem),
        .regwritew   (regwritew),
        .memtorege   (memtorege),
        .memtoregm   (memtoregm),
        .branchd     (branchd),
        .syscalle    (syscalle),
        .syscall_ack (syscall_ack),
        .stallf      (stallf),
        .stalld      (stalld),
        .flushe      (flushe),
        .forwardad   (forwardad),
        .forwardbd   (forwardbd),
        .forwardae   (forwardae),
        .forwardbe   (forwardbe),
        .syscall_req (syscall_req),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [4:0] rsd, rtd, rse, rte, wre, wrm, wrw;
        logic       rwe, rwm, rww, mte, mtm, br;
        logic       st, fad, fbd;
        logic [1:0] fae, fbe;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rsd = 0; rtd = 0; rse = 0; rte = 0;
        writerege = 0; writeregm = 0; writeregw = 0;
        regwritee = 0; regwritem = 0; regwritew = 0;
        memtorege = 0; memtoregm = 0; branchd = 0;
    endtask

    task automatic check_stall(input string name, input logic exp);
        check({name, ".stallf"}, 32'(stallf), 32'(exp));
        check({name, ".stalld"}, 32'(stalld), 32'(exp));
        check({name, ".flushe"}, 32'(flushe), 32'(exp));
    endtask

    vec_t vecs[$];

    function automatic vec_t mk(input string n,
        input logic [4:0] a_rsd, input logic [4:0] a_rtd, input logic [4:0] a_rse, input logic [4:0] a_rte,
        input logic [4:0] a_wre, input logic [4:0] a_wrm, input logic [4:0] a_wrw,
        input logic a_rwe, input logic a_rwm, input logic a_rww,
        input logic a_mte, input logic a_mtm, input logic a_br,
        input logic e_st, input logic [1:0] e_fae, input logic [1:0] e_fbe,
        input logic e_fad, input logic e_fbd);
        vec_t v;
        v.name = n;
        v.rsd = a_rsd; v.rtd = a_rtd; v.rse = a_rse; v.rte = a_rte;
        v.wre = a_wre; v.wrm = a_wrm; v.wrw = a_wrw;
        v.rwe = a_rwe; v.rwm = a_rwm; v.rww = a_rww;
        v.mte = a_mte; v.mtm = a_mtm; v.br = a_br;
        v.st = e_st; v.fae = e_fae; v.fbe = e_fbe; v.fad = e_fad; v.fbd = e_fbd;
        return v;
    endfunction

    initial begin
        //              name        rsd rtd rse rte wre wrm wrw rwe rwm rww mte mtm br  st  fae    fbe    fad fbd
        vecs.push_back(mk("idle",     0,  0,  0,  0,  0,  0,  0, 0,  0,  0,  0,  0,  0, 0, 2'b00, 2'b00, 0, 0));
        vecs.push_back(mk("ex_prio",  0,  0,  5,  0,  0,  5,  5, 0,  1,  1,  0,  0,  0, 0, 2'b10, 2'b00, 0, 0));
        vecs.push_back(mk("ex_r0",    0,  0,  0,  0,  0,  5,  5, 0,  1,  1,  0,  0,  0, 0, 2'b00, 2'b00, 0, 0));
        vecs.push_back(mk("ex_wb",    0,  0,  5,  0,  0,  5,  5, 0,  0,  1,  0,  0,  0, 0, 2'b01, 2'b00, 0, 0));
        vecs.push_back(mk("ex_mix",   0,  0,  5,  7,  0,  7,  5, 0,  1,  1,  0,  0,  0, 0, 2'b01, 2'b10, 0, 0));
        vecs.push_back(mk("ex_nowr",  0,  0,  5,  5,  0,  5,  5, 0,  0,  0,  0,  0,  0, 0, 2'b00, 2'b00, 0, 0));
        vecs.push_back(mk("lw_rs",    8,  0,  0,  8,  0,  0,  0, 0,  0,  0,  1,  0,  0, 1, 2'b00, 2'b00, 0, 0));
        vecs.push_back(mk("lw_none",  9,  0,  0,  8,  0,  0,  0, 0,  0,  0,  1,  0,  0, 0, 2'b00, 2'b00, 0, 0));
        vecs.push_back(mk("lw_rt",    1,  4,  0,  4,  0,  0,  0, 0,  0,  0,  1,  0,  0, 1, 2'b00, 2'b00, 0, 0));
        vecs.push_back(mk("lw_zero",  0,  0,  0,  0,  0,  0,  0, 0,  0,  0,  1,  0,  0, 1, 2'b00, 2'b00, 0, 0));
        vecs.push_back(mk("br_ex",    3,  0,  0,  0,  3,  0,  0, 1,  0,  0,  0,  0,  1, 1, 2'b00, 2'b00, 0, 0));
        vecs.push_back(mk("br_fwd",   3,  0,  0,  0,  0,  3,  0, 0,  1,  0,  0,  0,  1, 0, 2'b00, 2'b00, 1, 0));
        vecs.push_back(mk("br_ld",    2,  6,  0,  0,  0,  6,  0, 0,  1,  0,  0,  1,  1, 1, 2'b00, 2'b00, 0, 1));
        vecs.push_back(mk("lw_br",    3,  0,  0,  3,  3,  0,  0, 1,  0,  0,  1,  0,  1, 1, 2'b00, 2'b00, 0, 0));
        vecs.push_back(mk("r0_wr",    0,  0,  0,  0,  0,  0,  0, 0,  1,  1,  0,  0,  0, 0, 2'b00, 2'b00, 0, 0));
    end

    initial begin
        int waited;
        clear_inputs();
        syscalle    = 1'b0;
        syscall_ack = 1'b0;
        reset       = 1'b1;

        // Reset state; a syscall held in reset must not stall.
        #2;
        syscalle = 1'b1;
        #1;
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.req", 32'(syscall_req), 32'd0);
        check_stall("rst", 1'b0);
        syscalle = 1'b0;
        #9;
        reset = 1'b0;
        tick();
        check("post_rst.busy", 32'(busy), 32'd0);

        // Combinational vectors in RUN.
        for (int i = 0; i < vecs.size(); i++) begin
            rsd = vecs[i].rsd; rtd = vecs[i].rtd; rse = vecs[i].rse; rte = vecs[i].rte;
            writerege = vecs[i].wre; writeregm = vecs[i].wrm; writeregw = vecs[i].wrw;
            regwritee = vecs[i].rwe; regwritem = vecs[i].rwm; regwritew = vecs[i].rww;
            memtorege = vecs[i].mte; memtoregm = vecs[i].mtm; branchd = vecs[i].br;
            #1;
            check_stall(vecs[i].name, vecs[i].st);
            check({vecs[i].name, ".fae"}, 32'(forwardae), 32'(vecs[i].fae));
            check({vecs[i].name, ".fbe"}, 32'(forwardbe), 32'(vecs[i].fbe));
            check({vecs[i].name, ".fad"}, 32'(forwardad), 32'(vecs[i].fad));
            check({vecs[i].name, ".fbd"}, 32'(forwardbd), 32'(vecs[i].fbd));
            tick();
        end

        // Load-use stall lasts one cycle once the load moves on.
        clear_inputs();
        memtorege = 1; rte = 8; rsd = 8;
        #1;
        check_stall("lw_seq0", 1'b1);
        tick();
        memtorege = 0;
        #1;
        check_stall("lw_seq1", 1'b0);
        check("lw_seq1.busy", 32'(busy), 32'd0);
        clear_inputs();

        // Syscall sequence, DRAIN_CYCLES=2. Edge 0 samples syscalle.
        tick();
        syscalle = 1'b1;
        #1;
        check_stall("sc_pre", 1'b1);
        check("sc_pre.busy", 32'(busy), 32'd0);
        tick();                     // edge 0
        syscalle = 1'b0;
        #1;
        check("sc_e0.busy", 32'(busy), 32'd1);
        check("sc_e0.req", 32'(syscall_req), 32'd0);
        check_stall("sc_e0", 1'b1);
        tick();                     // edge 1
        check("sc_e1.busy", 32'(busy), 32'd1);
        check("sc_e1.req", 32'(syscall_req), 32'd0);
        tick();                     // edge 2
        check("sc_e2.req", 32'(syscall_req), 32'd1);
        syscalle = 1'b1;            // ignored outside RUN
        tick();                     // edge 3
        syscalle = 1'b0;
        check("sc_e3.req", 32'(syscall_req), 32'd1);
        check("sc_e3.busy", 32'(busy), 32'd1);
        tick();                     // edge 4
        check("sc_e4.req", 32'(syscall_req), 32'd1);
        syscall_ack = 1'b1;
        tick();                     // edge 5
        check("sc_e5.req", 32'(syscall_req), 32'd0);
        check("sc_e5.busy", 32'(busy), 32'd1);
        tick();                     // edge 6
        check("sc_e6.busy", 32'(busy), 32'd1);
        check_stall("sc_e6", 1'b1);
        syscall_ack = 1'b0;
        tick();                     // edge 7
        check("sc_e7.busy", 32'(busy), 32'd0);
        check_stall("sc_e7", 1'b0);

        // Reset asserted while in REQ.
        syscalle = 1'b1;
        tick();
        syscalle = 1'b0;
        waited = 0;
        while (syscall_req !== 1'b1 && waited < 10) begin
            tick();
            waited++;
        end
        check("rq.reached_req", 32'(syscall_req), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rq.req_async", 32'(syscall_req), 32'd0);
        check("rq.busy_async", 32'(busy), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check("rq.run", 32'(busy), 32'd0);

        // Restart after reset: req again exactly two edges after syscalle.
        syscalle = 1'b1;
        tick();
        syscalle = 1'b0;
        check("rs_e0.busy", 32'(busy), 32'd1);
        tick();
        check("rs_e1.req", 32'(syscall_req), 32'd0);
        tick();
        check("rs_e2.req", 32'(syscall_req), 32'd1);
        syscall_ack = 1'b1;
        tick();
        check("rs_ack.req", 32'(syscall_req), 32'd0);
        syscall_ack = 1'b0;
        tick();
        check("rs_done.busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
